// File: rtl/mm_master.sv
// mm_master: single-outstanding command-to-Avalon-MM master bridge.
//
// A command (read or write) is accepted from the cmd_* handshake only in IDLE,
// issued on the Avalon-MM master port, and completed with a one-cycle rsp_valid
// pulse. A transfer stuck in REQ or WAITDATA for TIMEOUT cycles is aborted and
// reported with rsp_error (reads then return ERR_DATA).
//
// Ports:
//   clock, reset            sole clock; asynchronous active-high reset
//   cmd_valid / cmd_ready   command handshake (ready only in IDLE)
//   cmd_write               1 = write, 0 = read
//   cmd_address             byte address (bits [1:0] forced to 0 on issue)
//   cmd_writedata           write data
//   cmd_byteenable          write byte lanes (reads always use 4'b1111)
//   rsp_valid               one-cycle completion pulse
//   rsp_readdata            read result, held until the next rsp_valid
//   rsp_error               completion was a timeout abort (valid with rsp_valid)
//   avm_*                   Avalon-MM master port (all outputs registered)
module mm_master #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_address,
    input  logic [31:0] cmd_writedata,
    input  logic [3:0]  cmd_byteenable,
    output logic        rsp_valid,
    output logic [31:0] rsp_readdata,
    output logic        rsp_error,
    output logic [31:0] avm_address,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    output logic        avm_write,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAITDATA, RESP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          is_write, is_write_n;
    logic [31:0]   avm_address_n, avm_writedata_n, rsp_readdata_n;
    logic [3:0]    avm_byteenable_n;
    logic          avm_write_n, avm_read_n, rsp_valid_n, rsp_error_n;
    logic          done, abort;
    logic          timeout_hit;

    // Gated with reset so no handshake appears to complete while held in reset.
    assign cmd_ready   = (state == IDLE) && !reset;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));

    // NOTE: every register, including the datapath copies, has a reset value so
    // the Avalon port shows a clean all-zero state the moment reset rises.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            is_write       <= 1'b0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_error      <= 1'b0;
            rsp_readdata   <= '0;
        end else begin
            // NOTE: non-blocking so all registers update from pre-edge values.
            state          <= state_n;
            cnt            <= cnt_n;
            is_write       <= is_write_n;
            avm_address    <= avm_address_n;
            avm_byteenable <= avm_byteenable_n;
            avm_writedata  <= avm_writedata_n;
            avm_write      <= avm_write_n;
            avm_read       <= avm_read_n;
            rsp_valid      <= rsp_valid_n;
            rsp_error      <= rsp_error_n;
            rsp_readdata   <= rsp_readdata_n;
        end
    end

    always_comb begin
        // NOTE: defaults first; any path that skips an assignment would
        // otherwise infer a latch.
        state_n          = state;
        cnt_n            = cnt;
        is_write_n       = is_write;
        avm_address_n    = avm_address;
        avm_byteenable_n = avm_byteenable;
        avm_writedata_n  = avm_writedata;
        avm_write_n      = avm_write;
        avm_read_n       = avm_read;
        rsp_valid_n      = 1'b0;
        rsp_error_n      = 1'b0;
        rsp_readdata_n   = rsp_readdata;
        done             = 1'b0;
        abort            = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    avm_address_n    = cmd_address & ~32'h3;
                    avm_writedata_n  = cmd_writedata;
                    avm_byteenable_n = cmd_write ? cmd_byteenable : 4'b1111;
                    avm_write_n      = cmd_write;
                    avm_read_n       = !cmd_write;
                    is_write_n       = cmd_write;
                    cnt_n            = '0;
                    state_n          = REQ;
                end
            end
            REQ: begin
                if (!avm_waitrequest) begin
                    avm_write_n = 1'b0;
                    avm_read_n  = 1'b0;
                    // A transfer the slave completes this cycle wins over a
                    // timeout reaching its limit in the same cycle.
                    if (is_write) begin
                        done = 1'b1;
                    end else if (avm_readdatavalid) begin
                        done           = 1'b1;
                        rsp_readdata_n = avm_readdata;
                    end else if (timeout_hit) begin
                        abort = 1'b1;
                    end else begin
                        cnt_n   = cnt + CW'(1);
                        state_n = WAITDATA;
                    end
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAITDATA: begin
                if (avm_readdatavalid) begin
                    done           = 1'b1;
                    rsp_readdata_n = avm_readdata;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (done || abort) begin
            avm_write_n = 1'b0;
            avm_read_n  = 1'b0;
            rsp_valid_n = 1'b1;
            rsp_error_n = abort;
            if (abort && !is_write) begin
                rsp_readdata_n = ERR_DATA;
            end
            state_n = RESP;
        end
    end

endmodule

// File: tb/tb_mm_master.sv
// Self-checking bench for mm_master (TIMEOUT = 8). Each transaction's cycle
// timeline is derived arithmetically from the slave's wait and data latency,
// and a negedge compare process checks the DUT against it every cycle. A few
// literal expectations from hand-worked examples pin the model.
module tb_mm_master;

    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_address = '0, cmd_writedata = '0;
    logic [3:0]  cmd_byteenable = '0;
    logic        cmd_ready, rsp_valid, rsp_error;
    logic [31:0] rsp_readdata, avm_address, avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_write, avm_read;
    logic        avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata = '0;

    always #5 clock = ~clock;

    mm_master #(.TIMEOUT(T), .ERR_DATA(ERR)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
        .cmd_byteenable(cmd_byteenable),
        .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_write(avm_write), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    int checks = 0, failures = 0;
    int cyc = 0;

    // Expected per-cycle outputs, set by the stimulus alongside the inputs.
    bit          chk_en = 1'b0;
    logic        exp_ready, exp_wr, exp_rd, exp_rv, exp_err;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] last_rdata = '0;

    // Observations used by the literal checks.
    int          strobe_total = 0, rsp_cyc = 0, acc_cyc = 0;
    logic [31:0] seen_addr = '0, seen_wdata = '0, rsp_data = '0;
    logic [3:0]  seen_be = '0;
    logic        rsp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (chk_en) begin
            check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
            check("avm_write", 32'(avm_write), 32'(exp_wr));
            check("avm_read", 32'(avm_read), 32'(exp_rd));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check("rsp_readdata", rsp_readdata, exp_rdata);
            if (exp_wr || exp_rd) begin
                check("avm_address", avm_address, exp_addr);
                check("avm_byteenable", 32'(avm_byteenable), 32'(exp_be));
                check("avm_writedata", avm_writedata, exp_wdata);
            end
            if (exp_rv) check("rsp_error", 32'(rsp_error), 32'(exp_err));
        end
        if (avm_write || avm_read) begin
            strobe_total <= strobe_total + 1;
            seen_addr    <= avm_address;
            seen_wdata   <= avm_writedata;
            seen_be      <= avm_byteenable;
        end
        if (rsp_valid) begin
            rsp_cyc  <= cyc;
            rsp_data <= rsp_readdata;
            rsp_err  <= rsp_error;
        end
    end

    function automatic logic coin(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic junk_cmd();
        cmd_valid      = 1'($urandom_range(0, 1));
        cmd_write      = 1'($urandom_range(0, 1));
        cmd_address    = $urandom;
        cmd_writedata  = $urandom;
        cmd_byteenable = 4'($urandom);
    endtask

    // One command. The slave holds waitrequest for w cycles of the strobe,
    // returns read data l cycles after accepting (never, if 'never'), then the
    // bench idles for gap cycles. k counts cycles spent in REQ/WAITDATA.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int w, input int l, input bit never,
                           input logic [31:0] rdata, input int gap);
        int d, c, s;
        bit ab;
        d = never ? 1000000 : w + l;
        if (wr) begin ab = (w > T); c = ab ? T : w; end
        else    begin ab = (d > T); c = ab ? T : d; end
        s = (w < c) ? w : c;          // last k with the strobe up

        cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr;
        cmd_writedata = wdata; cmd_byteenable = be;
        avm_waitrequest = 1'($urandom_range(0, 1));
        avm_readdatavalid = coin(30); avm_readdata = $urandom;
        exp_ready = 1'b1; exp_wr = 1'b0; exp_rd = 1'b0; exp_rv = 1'b0;
        exp_rdata = last_rdata;
        acc_cyc = cyc;
        step();

        exp_addr = {addr[31:2], 2'b00};
        exp_be = wr ? be : 4'hF;
        exp_wdata = wdata;
        for (int k = 0; k <= c; k++) begin
            junk_cmd();
            avm_waitrequest = (k < w) ? 1'b1 : (k == w) ? 1'b0 : 1'($urandom_range(0, 1));
            if (wr) begin
                avm_readdatavalid = coin(30);
                avm_readdata = $urandom;
            end else begin
                avm_readdatavalid = !never && (k == d);
                avm_readdata = avm_readdatavalid ? rdata : $urandom;
            end
            exp_ready = 1'b0; exp_wr = wr && (k <= s); exp_rd = !wr && (k <= s); exp_rv = 1'b0;
            step();
        end

        junk_cmd();
        avm_waitrequest = 1'($urandom_range(0, 1));
        avm_readdatavalid = coin(30); avm_readdata = $urandom;
        if (!wr) last_rdata = ab ? ERR : rdata;
        exp_ready = 1'b0; exp_wr = 1'b0; exp_rd = 1'b0; exp_rv = 1'b1;
        exp_err = ab; exp_rdata = last_rdata;
        step();

        for (int g = 0; g < gap; g++) begin
            cmd_valid = 1'b0;
            avm_waitrequest = 1'($urandom_range(0, 1));
            avm_readdatavalid = coin(30); avm_readdata = $urandom;
            exp_ready = 1'b1; exp_rv = 1'b0;
            step();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " avm_write"}, 32'(avm_write), 32'd0);
        check({tag, " avm_read"}, 32'(avm_read), 32'd0);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " rsp_error"}, 32'(rsp_error), 32'd0);
        check({tag, " rsp_readdata"}, rsp_readdata, 32'd0);
        check({tag, " avm_address"}, avm_address, 32'd0);
        check({tag, " avm_writedata"}, avm_writedata, 32'd0);
        check({tag, " avm_byteenable"}, 32'(avm_byteenable), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int a1, snap;
        logic        wr, never;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
        int          w, l, gap;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b0;
        exp_ready = 1'b1; exp_wr = 1'b0; exp_rd = 1'b0; exp_rv = 1'b0; exp_err = 1'b0;
        exp_rdata = '0;
        chk_en = 1'b1;
        step();

        // Zero-wait write; back-to-back command accepted three cycles later.
        snap = strobe_total;
        run_txn(1'b1, 32'h4, 32'h12345678, 4'hF, 0, 0, 1'b0, '0, 0);
        a1 = acc_cyc;
        check("wr latency", 32'(rsp_cyc - acc_cyc), 32'd2);
        check("wr strobe cycles", 32'(strobe_total - snap), 32'd1);
        check("wr address", seen_addr, 32'h4);
        check("wr data", seen_wdata, 32'h12345678);
        check("wr be", 32'(seen_be), 32'hF);
        check("wr error", 32'(rsp_err), 32'd0);
        run_txn(1'b1, 32'h8, 32'h0BADF00D, 4'h3, 0, 0, 1'b0, '0, 1);
        check("next accept", 32'(acc_cyc - a1), 32'd3);

        // Read from unaligned address, data returned with acceptance.
        snap = strobe_total;
        run_txn(1'b0, 32'h6, 32'h0, 4'h0, 0, 0, 1'b0, 32'hCAFEF00D, 1);
        check("rd address", seen_addr, 32'h4);
        check("rd strobe cycles", 32'(strobe_total - snap), 32'd1);
        check("rd be", 32'(seen_be), 32'hF);
        check("rd latency", 32'(rsp_cyc - acc_cyc), 32'd2);
        check("rd data", rsp_data, 32'hCAFEF00D);

        // Write stalled three cycles.
        snap = strobe_total;
        run_txn(1'b1, 32'h20, 32'hA5A5A5A5, 4'hC, 3, 0, 1'b0, '0, 1);
        check("stall strobe cycles", 32'(strobe_total - snap), 32'd4);
        check("stall latency", 32'(rsp_cyc - acc_cyc), 32'd5);

        // Read whose data never comes back: timeout abort.
        run_txn(1'b0, 32'h30, 32'h0, 4'h0, 0, 0, 1'b1, '0, 2);
        check("to latency", 32'(rsp_cyc - acc_cyc), 32'd10);
        check("to error", 32'(rsp_err), 32'd1);
        check("to data", rsp_data, 32'hDEADBEEF);

        // Write the slave never accepts: timeout with strobe held to the end.
        snap = strobe_total;
        run_txn(1'b1, 32'h40, 32'h11111111, 4'hF, 12, 0, 1'b0, '0, 1);
        check("wto strobe cycles", 32'(strobe_total - snap), 32'd9);
        check("wto error", 32'(rsp_err), 32'd1);

        // Empty byte-enable write goes out unchanged; late read data.
        run_txn(1'b1, 32'h50, 32'h22222222, 4'h0, 0, 0, 1'b0, '0, 0);
        check("be0 be", 32'(seen_be), 32'd0);
        run_txn(1'b0, 32'h54, 32'h0, 4'h0, 1, 2, 1'b0, 32'h5EED1234, 1);
        check("late rd latency", 32'(rsp_cyc - acc_cyc), 32'd5);
        check("late rd data", rsp_data, 32'h5EED1234);

        // Reset asserted while waiting for read data.
        chk_en = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'h100;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        step();
        cmd_valid = 1'b0;
        repeat (3) step();
        #2 reset = 1'b1;
        #1 check_reset_values("mid reset");
        @(posedge clock);
        #1;
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        last_rdata = '0;
        exp_ready = 1'b1; exp_wr = 1'b0; exp_rd = 1'b0; exp_rv = 1'b0; exp_rdata = '0;
        chk_en = 1'b1;
        repeat (4) begin
            avm_readdatavalid = 1'b1; avm_readdata = $urandom;
            step();
        end
        avm_readdatavalid = 1'b0;

        // Randomized traffic.
        repeat (300) begin
            wr    = 1'($urandom_range(0, 1));
            addr  = $urandom;
            wdata = $urandom;
            be    = 4'($urandom);
            rdata = $urandom;
            w     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 11) : $urandom_range(0, 2);
            l     = $urandom_range(0, 3);
            never = ($urandom_range(0, 7) == 0);
            gap   = $urandom_range(0, 2);
            run_txn(wr, addr, wdata, be, w, l, never, rdata, gap);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
